video_pixel_feeder: RTL and testbench
=====================================

Name: video_pixel_feeder

Overview:
- Pixel source for the HDMI timing generator.
- Receives a frame-ordered RGB888 stream from the DDR frame-buffer reader over valid/ready, buffers it in a FIFO, and prefills before each display frame.
- Returns one pixel per data_req, one cycle later, so the pixel lines up with the generator's active-video window.
- Handles startup alignment, frame re-synchronisation and underflow without losing frame lock.

Parameters:
- H_DISP, 1920: active pixels per line.
- V_DISP, 1080: active lines per frame.
- FIFO_AW, 11: FIFO address width; depth = 2**FIFO_AW.
- PREFILL, 1024: FIFO level required before arming; must be < 2**FIFO_AW.
- FILL_RGB, 24'h000000: colour driven when no valid pixel is available.

Ports:
- pixel_clk  in  1  sole clock.
- sys_rst  in  1  synchronous, active-high reset.
- s_pix_valid  in  1  upstream pixel valid.
- s_pix_data  in  24  upstream RGB888 pixel.
- s_pix_sof  in  1  marks the first pixel of a frame; qualified by s_pix_valid.
- s_pix_ready  out  1  feeder accepts the pixel this cycle.
- frame_req  out  1  one-cycle pulse telling the DDR reader to start fetching a frame.
- video_vs  in  1  vertical sync from the timing generator, active low.
- data_req  in  1  pixel request from the timing generator.
- pixel_data  out  24  pixel returned one cycle after data_req.
- underflow_cnt  out  16  saturating count of requests served while the FIFO was empty.
- skip_cnt  out  16  saturating count of display frames missed because the FIFO was not ready.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, pixel_clk. Reset sys_rst is synchronous and active-high.
- Reset values:
  - state S_REQ; FIFO empty.
  - pixel_data = 0, frame_req = 0, s_pix_ready = 0.
  - underflow_cnt = 0, skip_cnt = 0, fifo_level = 0.
  - pix_cnt = 0; vs_d = 1.
- Reset mid-frame aborts everything. Re-alignment happens at the next vs falling edge after prefill.
- vs_fall = vs_d & ~video_vs, where vs_d is video_vs registered.
- FSM:
  - S_REQ: FIFO cleared synchronously; frame_req = 1 for exactly this cycle; s_pix_ready = 0. Next state S_FILL.
  - S_FILL: s_pix_ready = !full.
    - While the FIFO is empty, accepted pixels with s_pix_sof = 0 are discarded (stale tail of a previous fetch). The first sof pixel is written.
    - When fifo_level >= PREFILL, go to S_ARMED.
    - vs_fall in this state increments skip_cnt; state unchanged.
  - S_ARMED: keeps filling. On vs_fall go to S_STREAM with pix_cnt = 0.
  - S_STREAM: keeps filling.
    - Each data_req pops one FIFO word and increments pix_cnt.
    - When pix_cnt reaches H_DISP*V_DISP - 1 and data_req is high, go to S_REQ (prefetch of the next frame during vertical blank).
    - vs_fall in S_STREAM before the count completes is a lost frame: increment skip_cnt, go to S_REQ.
- Output timing:
  - pixel_data is registered: the value for data_req at cycle t appears at t+1 and holds until the next data_req.
  - A data_req in any state other than S_STREAM produces FILL_RGB, with no pop and no count.
- Underflow: data_req in S_STREAM with the FIFO empty:
  - pixel_data = FILL_RGB; pix_cnt still advances, so frame alignment is preserved.
  - underflow_cnt increments, saturating at 16'hFFFF.
- FIFO:
  - Simultaneous push and pop leave the level unchanged.
  - Push is blocked when full, via s_pix_ready low.
  - Pop is never issued when empty.
  - Pointers wrap modulo 2**FIFO_AW; occupancy is held in FIFO_AW+1 bits.
- s_pix_sof seen while the FIFO is non-empty is stored as ordinary data; the marker is ignored.
- pix_cnt width is ceil(log2(H_DISP*V_DISP)) = 21 bits for the defaults.

Decomposition:
- Shared package/header: state encodings (S_REQ, S_FILL, S_ARMED, S_STREAM), RGB width 24, counter width 16.
- Sub-module sync_fifo: single clock, registered read; parameters DW = 24 and AW = FIFO_AW; provides a synchronous clear, full, empty and level.

Test Plan:
All scenarios use H_DISP=8, V_DISP=4, FIFO_AW=4, PREFILL=8.
- Reset release, upstream sends sof + 31 pixels 0..31 at full rate, then vs_fall, then 32 data_req → frame_req pulses once at cycle 1; pixel_data returns 0..31, each one cycle after its data_req; underflow_cnt = 0; FSM returns to S_REQ and pulses frame_req again.
- Upstream sends 5 non-sof pixels, then sof pixel 0xA0 → first popped value is 0xA0; the 5 pixels are discarded.
- vs_fall while the FIFO holds only 3 pixels → skip_cnt = 1; FSM stays in S_FILL; streaming starts at the following vs_fall once level >= 8.
- Upstream stalls after 10 pixels during streaming → requests 11..32 return FILL_RGB; underflow_cnt = 22; FSM reaches S_REQ after the 32nd request.
- FIFO full (16 entries) with no data_req → s_pix_ready low and fifo_level = 16. Then simultaneous valid and data_req for 4 cycles → level stays 16 and the order is preserved.
- sys_rst asserted for 1 cycle mid-S_STREAM → next cycle all outputs and counters are 0 and state is S_REQ; frame_req pulses the cycle after reset deasserts.

Source files
------------

// File: rtl/video_pixel_feeder_pkg.sv
// Shared types and widths for the video pixel feeder: FSM encoding, pixel and
// counter widths, and a saturating increment helper.
package video_pixel_feeder_pkg;

    localparam int unsigned RGB_W = 24;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_FILL   = 2'd1,
        S_ARMED  = 2'd2,
        S_STREAM = 2'd3
    } feeder_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/video_pixel_feeder_sync_fifo.sv
// Single-clock FIFO with registered read data, synchronous clear and an
// occupancy count one bit wider than the pointers.
module video_pixel_feeder_sync_fifo #(
    parameter int unsigned DW = 24,
    parameter int unsigned AW = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] mem_q [Depth];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i && !rst_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // rdata_q is left alone by clear so the last popped pixel keeps being shown.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rdata_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    assign rdata_o = rdata_q;
    assign full_o  = (level_q == (AW+1)'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/video_pixel_feeder.sv
// Pixel source for the HDMI timing generator: buffers the frame-buffer stream,
// prefills before each frame and returns one pixel per data_req a cycle later.
module video_pixel_feeder
    import video_pixel_feeder_pkg::*;
#(
    parameter int unsigned      H_DISP   = 1920,
    parameter int unsigned      V_DISP   = 1080,
    parameter int unsigned      FIFO_AW  = 11,
    parameter int unsigned      PREFILL  = 1024,
    parameter logic [RGB_W-1:0] FILL_RGB = 24'h000000
) (
    input  logic               pixel_clk,
    input  logic               sys_rst,
    input  logic               s_pix_valid,
    input  logic [RGB_W-1:0]   s_pix_data,
    input  logic               s_pix_sof,
    output logic               s_pix_ready,
    output logic               frame_req,
    input  logic               video_vs,
    input  logic               data_req,
    output logic [RGB_W-1:0]   pixel_data,
    output logic [CNT_W-1:0]   underflow_cnt,
    output logic [CNT_W-1:0]   skip_cnt,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int unsigned    Total   = H_DISP * V_DISP;
    localparam int unsigned    CntW    = $clog2(Total);
    localparam logic [CntW-1:0] LastPix = CntW'(Total - 1);

    feeder_state_e    state_q, state_d;
    logic [CntW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] underflow_q, underflow_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             vs_d_q;
    logic             served_q, served_d;
    logic             popped_q, popped_d;

    logic             fifo_clr, fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [RGB_W-1:0] fifo_rdata;
    logic [FIFO_AW:0] fifo_lvl;
    logic             vs_fall;
    logic             last_req;

    assign vs_fall  = vs_d_q & ~video_vs;
    assign last_req = data_req && (pix_cnt_q == LastPix);

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        underflow_d = underflow_q;
        skip_d      = skip_q;
        served_d    = served_q;
        popped_d    = popped_q;
        fifo_clr    = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        s_pix_ready = 1'b0;
        frame_req   = 1'b0;

        if (data_req) begin
            served_d = 1'b1;
            popped_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                fifo_clr  = 1'b1;
                frame_req = !sys_rst;
                state_d   = S_FILL;
            end
            S_FILL: begin
                s_pix_ready = !fifo_full;
                // Until a frame start lands, anything arriving is a stale tail.
                fifo_push   = s_pix_valid && s_pix_ready && (!fifo_empty || s_pix_sof);
                if (fifo_lvl >= (FIFO_AW+1)'(PREFILL)) begin
                    state_d = S_ARMED;
                end
                if (vs_fall) begin
                    skip_d = sat_inc(skip_q);
                end
            end
            S_ARMED: begin
                s_pix_ready = !fifo_full;
                fifo_push   = s_pix_valid && s_pix_ready;
                if (vs_fall) begin
                    state_d   = S_STREAM;
                    pix_cnt_d = '0;
                end
            end
            S_STREAM: begin
                if (data_req) begin
                    fifo_pop = !fifo_empty;
                    popped_d = !fifo_empty;
                    if (fifo_empty) begin
                        underflow_d = sat_inc(underflow_q);
                    end
                    if (last_req) begin
                        state_d = S_REQ;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CntW'(1);
                    end
                end
                if (vs_fall && !last_req) begin
                    skip_d  = sat_inc(skip_q);
                    state_d = S_REQ;
                end
                // A same-cycle pop frees the slot, so a full FIFO can still accept.
                s_pix_ready = !fifo_full || fifo_pop;
                fifo_push   = s_pix_valid && s_pix_ready;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_q     <= S_REQ;
            pix_cnt_q   <= '0;
            underflow_q <= '0;
            skip_q      <= '0;
            vs_d_q      <= 1'b1;
            served_q    <= 1'b0;
            popped_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            underflow_q <= underflow_d;
            skip_q      <= skip_d;
            vs_d_q      <= video_vs;
            served_q    <= served_d;
            popped_q    <= popped_d;
        end
    end

    video_pixel_feeder_sync_fifo #(
        .DW(RGB_W),
        .AW(FIFO_AW)
    ) u_fifo (
        .clk_i  (pixel_clk),
        .rst_i  (sys_rst),
        .clr_i  (fifo_clr),
        .push_i (fifo_push),
        .wdata_i(s_pix_data),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .level_o(fifo_lvl)
    );

    always_comb begin
        pixel_data = '0;
        if (served_q) begin
            pixel_data = popped_q ? fifo_rdata : FILL_RGB;
        end
    end

    assign underflow_cnt = underflow_q;
    assign skip_cnt      = skip_q;
    assign fifo_level    = fifo_lvl;

endmodule

// File: tb/tb_video_pixel_feeder.sv
// Scoreboard bench for video_pixel_feeder on a small 8x4 frame with a
// 16-entry FIFO.
module tb_video_pixel_feeder;
    import video_pixel_feeder_pkg::*;

    localparam int unsigned H     = 8;
    localparam int unsigned V     = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned PRE   = 8;
    localparam int unsigned TOTAL = H * V;
    localparam int unsigned DEPTH = 16;
    localparam logic [23:0] FILL  = 24'h0F0F0F;

    logic        pixel_clk;
    logic        sys_rst;
    logic        s_pix_valid;
    logic [23:0] s_pix_data;
    logic        s_pix_sof;
    logic        s_pix_ready;
    logic        frame_req;
    logic        video_vs;
    logic        data_req;
    logic [23:0] pixel_data;
    logic [15:0] underflow_cnt;
    logic [15:0] skip_cnt;
    logic [AW:0] fifo_level;

    video_pixel_feeder #(
        .H_DISP  (H),
        .V_DISP  (V),
        .FIFO_AW (AW),
        .PREFILL (PRE),
        .FILL_RGB(FILL)
    ) dut (
        .pixel_clk    (pixel_clk),
        .sys_rst      (sys_rst),
        .s_pix_valid  (s_pix_valid),
        .s_pix_data   (s_pix_data),
        .s_pix_sof    (s_pix_sof),
        .s_pix_ready  (s_pix_ready),
        .frame_req    (frame_req),
        .video_vs     (video_vs),
        .data_req     (data_req),
        .pixel_data   (pixel_data),
        .underflow_cnt(underflow_cnt),
        .skip_cnt     (skip_cnt),
        .fifo_level   (fifo_level)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    typedef enum int {M_REQ, M_FILL, M_ARMED, M_STREAM} m_state_e;
    typedef struct packed {
        logic        sof;
        logic [23:0] d;
    } pix_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    m_state_e    m_st   = M_REQ;
    logic [23:0] m_fifo [$];
    logic [23:0] out_q  [$];
    pix_t        src_q  [$];
    int          m_cnt  = 0;
    int          m_uf   = 0;
    int          m_skip = 0;
    bit          m_vsd  = 1'b1;
    bit          pend   = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check this cycle's outputs,
    // then advance the reference model at the rising edge.
    task automatic cyc(input bit rst, input bit req, input bit vs_low);
        pix_t        p;
        bit          v, acc, done, vsf, exp_rdy;
        int          sz0;
        logic [23:0] e;
        v = (src_q.size() > 0);
        p = v ? src_q[0] : '0;
        sys_rst     = rst;
        data_req    = req;
        video_vs    = !vs_low;
        s_pix_valid = v;
        s_pix_data  = p.d;
        s_pix_sof   = p.sof;
        #1;
        sz0 = m_fifo.size();
        if (chk_en) begin
            if (pend) begin
                e = out_q.pop_front();
                check_eq("pixel_data", pixel_data, e);
            end
            exp_rdy = (m_st != M_REQ) &&
                      (sz0 < DEPTH || (m_st == M_STREAM && req && sz0 > 0));
            check_eq("frame_req", frame_req, (m_st == M_REQ && !rst));
            check_eq("s_pix_ready", s_pix_ready, exp_rdy);
            check_eq("fifo_level", fifo_level, sz0);
            check_eq("underflow_cnt", underflow_cnt, m_uf);
            check_eq("skip_cnt", skip_cnt, m_skip);
        end
        pend = 1'b0;
        acc  = v && s_pix_ready;
        @(posedge pixel_clk);
        vsf  = m_vsd && vs_low;
        done = 1'b0;
        if (rst) begin
            m_st = M_REQ;
            m_fifo.delete();
            out_q.delete();
            m_uf   = 0;
            m_skip = 0;
            m_cnt  = 0;
            m_vsd  = 1'b1;
            chk_en = 1'b1;
        end else begin
            if (req) begin
                pend = 1'b1;
                if (m_st == M_STREAM && sz0 > 0) begin
                    out_q.push_back(m_fifo.pop_front());
                end else begin
                    out_q.push_back(FILL);
                    if (m_st == M_STREAM && m_uf < 65535) m_uf++;
                end
            end
            if (acc && !(m_st == M_FILL && sz0 == 0 && !p.sof)) m_fifo.push_back(p.d);
            case (m_st)
                M_REQ: begin
                    m_fifo.delete();
                    m_st = M_FILL;
                end
                M_FILL: begin
                    if (vsf) m_skip++;
                    if (sz0 >= PRE) m_st = M_ARMED;
                end
                M_ARMED: begin
                    if (vsf) begin
                        m_st  = M_STREAM;
                        m_cnt = 0;
                    end
                end
                default: begin
                    if (req) begin
                        if (m_cnt == TOTAL - 1) begin
                            m_st = M_REQ;
                            done = 1'b1;
                        end else begin
                            m_cnt++;
                        end
                    end
                    if (vsf && !done) begin
                        m_skip++;
                        m_st = M_REQ;
                    end
                end
            endcase
            m_vsd = !vs_low;
        end
        if (acc) void'(src_q.pop_front());
        @(negedge pixel_clk);
    endtask

    task automatic wait_level(input int lvl);
        int budget = 200;
        while (m_fifo.size() < lvl && budget > 0) begin
            cyc(1'b0, 1'b0, 1'b0);
            budget--;
        end
        if (m_fifo.size() < lvl) check_eq("prefill_timeout", m_fifo.size(), lvl);
    endtask

    task automatic run_frame(input int n_stale, input int n_pix, input logic [23:0] base,
                             input int early_lvl, input int arm_lvl, input int idle,
                             input int n_req, input int rst_at);
        for (int i = 0; i < n_stale; i++) src_q.push_back({1'b0, 24'h500000 + 24'(i)});
        for (int i = 0; i < n_pix; i++) src_q.push_back({(i == 0), base + 24'(i)});
        if (early_lvl > 0) begin
            wait_level(early_lvl);
            cyc(1'b0, 1'b0, 1'b1);
            check_eq("state_after_early_vs", dut.state_q, S_FILL);
        end
        wait_level(arm_lvl);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < idle; i++) cyc(1'b0, 1'b0, 1'b0);
        if (idle > 0) begin
            check_eq("full_ready_low", s_pix_ready, 1'b0);
            check_eq("full_level", fifo_level, DEPTH);
        end
        for (int k = 0; k < n_req; k++) begin
            if (k == rst_at) begin
                cyc(1'b1, 1'b0, 1'b0);
                check_eq("rst_pixel_data", pixel_data, 24'h0);
                check_eq("rst_underflow", underflow_cnt, 16'h0);
                check_eq("rst_skip", skip_cnt, 16'h0);
                check_eq("rst_level", fifo_level, 0);
                check_eq("rst_state", dut.state_q, S_REQ);
                src_q.delete();
                break;
            end
            cyc(1'b0, 1'b1, 1'b0);
            if (idle > 0 && k == 3) check_eq("level_hold", fifo_level, DEPTH);
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        src_q.delete();
    endtask

    initial begin
        sys_rst     = 1'b1;
        s_pix_valid = 1'b0;
        s_pix_data  = '0;
        s_pix_sof   = 1'b0;
        video_vs    = 1'b1;
        data_req    = 1'b0;
        @(negedge pixel_clk);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check_eq("reset_pixel_data", pixel_data, 24'h0);
        check_eq("reset_frame_req", frame_req, 1'b0);
        check_eq("reset_ready", s_pix_ready, 1'b0);
        check_eq("reset_underflow", underflow_cnt, 16'h0);
        check_eq("reset_skip", skip_cnt, 16'h0);
        check_eq("reset_level", fifo_level, 0);

        // Basic frame: sof + 31 pixels, 32 requests.
        run_frame(0, 32, 24'h000000, 0, PRE, 0, 32, -1);
        check_eq("s1_underflow", underflow_cnt, 16'h0);
        // Stale tail of five non-sof pixels ahead of the frame start.
        run_frame(5, 32, 24'h0000A0, 0, PRE, 0, 32, -1);
        // Early vs_fall with only 3 pixels buffered.
        run_frame(0, 32, 24'h100000, 3, PRE, 0, 32, -1);
        check_eq("s3_skip", skip_cnt, 16'd1);
        // Upstream stalls after 10 pixels.
        run_frame(0, 10, 24'h200000, 0, PRE, 0, 32, -1);
        check_eq("s4_underflow", underflow_cnt, 16'd22);
        // Full FIFO, then push and pop together.
        run_frame(0, 32, 24'h300000, 0, DEPTH, 2, 32, -1);
        // Reset in the middle of streaming.
        run_frame(0, 32, 24'h400000, 0, PRE, 0, 32, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
